// File: rtl/conv3_seq_ctrl.sv
// conv3_seq_ctrl: frame sequencer for a 3x3 column-streaming convolution filter.
// It resets the filter, loads KERNEL_SIZE kernel columns, streams NUM_COLS image columns
// under a credit limit sized to the output FIFO, and buffers the filter results in a
// first-word fall-through FIFO for the result sink. A watchdog ends the frame with err
// if the filter stops returning results.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   start / busy / done / err     frame control and status
//   kern_valid/ready, kern_col    kernel column source (one column per beat)
//   col_valid/ready, col_data     image column source
//   f_rst, f_kernel_load,         filter drive: reset, kernel-load mode, beat strobe,
//   f_valid_in, f_input_column,   image column and the three kernel column elements
//   f_kernel_column_0..2
//   f_valid_out, f_output_column  filter result return
//   out_valid/ready, out_col,     result sink; out_idx is the result column index
//   out_idx
module conv3_seq_ctrl #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned KERNEL_SIZE    = 3,
   parameter int unsigned INPUT_COL_SIZE = 12,
   parameter int unsigned NUM_COLS       = 12,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT        = 16,
   localparam int unsigned OUT_ROWS = INPUT_COL_SIZE - KERNEL_SIZE + 1,
   localparam int unsigned OUT_COLS = NUM_COLS - KERNEL_SIZE + 1,
   localparam int unsigned IDX_W    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          start,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          err,
   input  logic                                          kern_valid,
   output logic                                          kern_ready,
   input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]        kern_col,
   input  logic                                          col_valid,
   output logic                                          col_ready,
   input  logic [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0]     col_data,
   output logic                                          f_rst,
   output logic                                          f_kernel_load,
   output logic                                          f_valid_in,
   output logic [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0]     f_input_column,
   output logic [DATA_WIDTH-1:0]                         f_kernel_column_0,
   output logic [DATA_WIDTH-1:0]                         f_kernel_column_1,
   output logic [DATA_WIDTH-1:0]                         f_kernel_column_2,
   input  logic                                          f_valid_out,
   input  logic [OUT_ROWS-1:0][DATA_WIDTH-1:0]           f_output_column,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [OUT_ROWS-1:0][DATA_WIDTH-1:0]           out_col,
   output logic [IDX_W-1:0]                              out_idx
);

   localparam int unsigned KB_W  = $clog2(KERNEL_SIZE + 1);
   localparam int unsigned COL_W = $clog2(NUM_COLS + 1);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned POP_W = $clog2(OUT_COLS + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {StIdle, StFrst, StLoadk, StStream, StDrain, StDone} state_e;

   state_e              state_q;
   logic                busy_q, done_q, err_q;
   logic [KB_W-1:0]     kbeat_q;
   logic [COL_W-1:0]    col_cnt_q;
   logic [CNT_W-1:0]    inflight_q;
   logic [POP_W-1:0]    popped_q;
   logic [WD_W-1:0]     wd_cnt_q;

   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    fifo_count_q;
   logic [OUT_ROWS-1:0][DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                kern_fire, col_fire, credit_ok;
   logic [CNT_W:0]      credit_sum;
   logic                infl_inc, infl_dec;
   logic                push, do_push, pop, fifo_full, fifo_clr, wd_fire;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Every column sent to the filter may come back as a result, so results still inside
   // the filter are counted against the FIFO space; this is what keeps the FIFO from
   // overflowing even though f_valid_out has no backpressure.
   assign credit_sum = {1'b0, fifo_count_q} + {1'b0, inflight_q};
   assign credit_ok  = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);

   assign kern_ready    = (state_q == StLoadk);
   assign col_ready     = (state_q == StStream) && credit_ok;
   assign kern_fire     = kern_valid && kern_ready;
   assign col_fire      = col_valid && col_ready;
   assign f_kernel_load = (state_q == StLoadk);
   assign f_valid_in    = kern_fire || col_fire;
   assign f_rst         = !rst_n || (state_q == StFrst);

   assign f_input_column    = col_data;
   assign f_kernel_column_0 = kern_col[0];
   assign f_kernel_column_1 = kern_col[1];
   assign f_kernel_column_2 = kern_col[2];

   // The first KERNEL_SIZE-1 columns only prime the window and produce no result.
   assign infl_inc = col_fire && (col_cnt_q >= COL_W'(KERNEL_SIZE - 1));
   assign infl_dec = f_valid_out && (state_q != StIdle) && (inflight_q != '0);

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

   assign wd_fire = (state_q == StDrain) && (popped_q != POP_W'(OUT_COLS)) && !f_valid_out &&
                    (wd_cnt_q == WD_W'(TIMEOUT - 1)) && (inflight_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         kbeat_q    <= '0;
         col_cnt_q  <= '0;
         inflight_q <= '0;
         popped_q   <= '0;
         wd_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (infl_inc && !infl_dec) begin
            inflight_q <= inflight_q + CNT_W'(1);
         end else if (infl_dec && !infl_inc) begin
            inflight_q <= inflight_q - CNT_W'(1);
         end
         if (pop) begin
            popped_q <= popped_q + POP_W'(1);
         end
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StFrst;
                  busy_q     <= 1'b1;
                  err_q      <= 1'b0;
                  kbeat_q    <= '0;
                  col_cnt_q  <= '0;
                  inflight_q <= '0;
                  popped_q   <= '0;
                  wd_cnt_q   <= '0;
               end
            end
            StFrst: state_q <= StLoadk;
            StLoadk: begin
               if (kern_fire) begin
                  kbeat_q <= kbeat_q + KB_W'(1);
                  if (kbeat_q == KB_W'(KERNEL_SIZE - 1)) begin
                     state_q <= StStream;
                  end
               end
            end
            StStream: begin
               if (col_fire) begin
                  col_cnt_q <= col_cnt_q + COL_W'(1);
                  if (col_cnt_q == COL_W'(NUM_COLS - 1)) begin
                     state_q  <= StDrain;
                     wd_cnt_q <= '0;
                  end
               end
            end
            StDrain: begin
               if (popped_q == POP_W'(OUT_COLS)) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end else if (wd_fire) begin
                  err_q   <= 1'b1;
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end else if (f_valid_out) begin
                  wd_cnt_q <= '0;
               end else if (wd_cnt_q != WD_W'(TIMEOUT)) begin
                  wd_cnt_q <= wd_cnt_q + WD_W'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Result FIFO. Results arriving while idle belong to no frame and are dropped.
   assign push      = f_valid_out && (state_q != StIdle);
   assign out_valid = (fifo_count_q != '0);
   assign pop       = out_valid && out_ready;
   assign fifo_full = (fifo_count_q == CNT_W'(FIFO_DEPTH));
   assign do_push   = push && (!fifo_full || pop) && !fifo_clr;
   assign fifo_clr  = ((state_q == StIdle) && start) || wd_fire;
   assign out_col   = mem_q[rd_ptr_q];
   assign out_idx   = popped_q[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else if (fifo_clr) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (do_push && !pop) begin
            fifo_count_q <= fifo_count_q + CNT_W'(1);
         end else if (pop && !do_push) begin
            fifo_count_q <= fifo_count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= f_output_column;
      end
   end

endmodule

// File: tb/tb_conv3_seq_ctrl.sv
// tb_conv3_seq_ctrl: directed self-checking bench for conv3_seq_ctrl with a two-cycle
// filter model that sums each 3-element vertical window of the streamed column.
module tb_conv3_seq_ctrl;

   localparam int DW  = 16;
   localparam int KS  = 3;
   localparam int ICS = 12;
   localparam int NC  = 12;
   localparam int FD  = 4;
   localparam int TO  = 16;
   localparam int OR  = ICS - KS + 1;
   localparam int OC  = NC - KS + 1;

   typedef logic [KS-1:0][DW-1:0]  kcol_t;
   typedef logic [ICS-1:0][DW-1:0] icol_t;
   typedef logic [OR-1:0][DW-1:0]  ocol_t;

   logic clk, rst_n, start, busy, done, err;
   logic kern_valid, kern_ready, col_valid, col_ready;
   kcol_t kern_col;
   icol_t col_data, f_input_column;
   logic f_rst, f_kernel_load, f_valid_in, f_valid_out;
   logic [DW-1:0] f_kernel_column_0, f_kernel_column_1, f_kernel_column_2;
   ocol_t f_output_column, out_col;
   logic out_valid, out_ready;
   logic [3:0] out_idx;

   int n_total = 0;
   int n_bad   = 0;

   conv3_seq_ctrl #(
      .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .INPUT_COL_SIZE(ICS), .NUM_COLS(NC),
      .FIFO_DEPTH(FD), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .kern_valid(kern_valid), .kern_ready(kern_ready), .kern_col(kern_col),
      .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
      .f_rst(f_rst), .f_kernel_load(f_kernel_load), .f_valid_in(f_valid_in),
      .f_input_column(f_input_column), .f_kernel_column_0(f_kernel_column_0),
      .f_kernel_column_1(f_kernel_column_1), .f_kernel_column_2(f_kernel_column_2),
      .f_valid_out(f_valid_out), .f_output_column(f_output_column),
      .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_idx(out_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic kcol_t kern_beat(input int b);
      kcol_t k;
      for (int i = 0; i < KS; i++) k[i] = DW'(32'h1000 + b * 16 + i);
      return k;
   endfunction

   function automatic icol_t img_col(input int c);
      icol_t v;
      for (int r = 0; r < ICS; r++) v[r] = DW'(c * 256 + r);
      return v;
   endfunction

   // Result j comes from image column j+2: (256c+r)+(256c+r+1)+(256c+r+2).
   function automatic ocol_t exp_res(input int j);
      ocol_t v;
      for (int r = 0; r < OR; r++) v[r] = DW'(768 * (j + 2) + 3 * r + 3);
      return v;
   endfunction

   // Filter model: latency 2, optionally swallows the last result of the frame.
   bit    drop_last = 1'b0;
   logic  p1_v, p2_v;
   ocol_t p1_d, p2_d;
   int    mcol, mres;
   always @(posedge clk) begin
      if (f_rst) begin
         p1_v <= 1'b0;
         p2_v <= 1'b0;
         mcol <= 0;
         mres <= 0;
      end else begin
         p1_v <= 1'b0;
         if (f_valid_in && !f_kernel_load) begin
            mcol <= mcol + 1;
            if (mcol >= KS - 1) begin
               ocol_t s;
               for (int r = 0; r < OR; r++)
                  s[r] = f_input_column[r] + f_input_column[r+1] + f_input_column[r+2];
               p1_v <= 1'b1;
               p1_d <= s;
            end
         end
         if (p1_v) mres <= mres + 1;
         p2_v <= p1_v && !(drop_last && mres == OC - 1);
         p2_d <= p1_d;
      end
   end
   assign f_valid_out     = p2_v;
   assign f_output_column = p2_d;

   // Monitor, sampling on the falling edge.
   int    cyc = 0;
   int    exp_idx, kbeats, early_rdy, dones, last_fvo_edge, err_edge;
   bit    err_seen;
   kcol_t mon_k;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_idx = 0; kbeats = 0; early_rdy = 0; dones = 0; err_seen = 0;
      end else begin
         if (start && !busy) begin
            exp_idx = 0; kbeats = 0; early_rdy = 0; dones = 0; err_seen = 0;
         end
         if (f_valid_in && f_kernel_load) begin
            mon_k = kern_beat(kbeats);
            chk("kern_col0", f_kernel_column_0, mon_k[0]);
            chk("kern_col1", f_kernel_column_1, mon_k[1]);
            chk("kern_col2", f_kernel_column_2, mon_k[2]);
            kbeats++;
         end
         if (col_ready && kbeats < KS) early_rdy++;
         if (out_valid && out_ready) begin
            chk("out_idx", out_idx, exp_idx);
            chk("out_col", out_col, exp_res(exp_idx));
            exp_idx++;
         end
         if (done) dones++;
         if (f_valid_out) last_fvo_edge = cyc + 1;  // taken by the DUT at the next edge
         if (err && !err_seen) begin
            err_seen = 1;
            err_edge = cyc;
         end
      end
   end

   int next_col;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_kernel(input bit gaps);
      int b = 0;
      int g = 0;
      bit idle_slot = 1'b0;
      while (b < KS && g < 200) begin
         tick();
         g++;
         if (gaps && idle_slot) begin
            kern_valid = 1'b0;
            idle_slot  = 1'b0;
         end else begin
            kern_valid = 1'b1;
            kern_col   = kern_beat(b);
            if (kern_ready) begin
               b++;
               idle_slot = 1'b1;
            end
         end
      end
      tick();
      kern_valid = 1'b0;
   endtask

   task automatic feed_cols(input int stop_at, input int max_cyc, input int start_at);
      int g = 0;
      while (next_col < stop_at && g < max_cyc) begin
         tick();
         g++;
         start     = (next_col == start_at);
         col_valid = 1'b1;
         col_data  = img_col(next_col);
         if (col_ready) next_col++;
      end
      tick();
      col_valid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int g = 0;
      while (dones == 0 && g < max_cyc) begin
         tick();
         g++;
      end
      chk("done_seen", dones != 0, 1'b1);
   endtask

   task automatic run_frame(input bit gaps, input int start_at);
      do_start();
      load_kernel(gaps);
      next_col = 0;
      feed_cols(NC, 400, start_at);
      wait_done(400);
   endtask

   task automatic end_frame(input string tag, input int pops, input bit exp_err);
      repeat (3) tick();
      chk({tag, "_pops"}, exp_idx, pops);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_done_cnt"}, dones, 1);
      chk({tag, "_kbeats"}, kbeats, KS);
      chk({tag, "_early_col_ready"}, early_rdy, 0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; kern_valid = 1'b0; kern_col = '0;
      col_valid = 1'b0; col_data = '0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_outputs",
          {busy, done, err, kern_ready, col_ready, out_valid, f_kernel_load, f_valid_in, f_rst},
          9'b0000_0000_1);
      repeat (2) tick();
      rst_n = 1'b1;
      #1;
      chk("f_rst_released", f_rst, 1'b0);

      // Nominal frame.
      out_ready = 1'b1;
      run_frame(1'b0, -1);
      end_frame("nominal", OC, 1'b0);

      // Backpressure: no pops, columns stall once four results are owed.
      out_ready = 1'b0;
      do_start();
      load_kernel(1'b0);
      next_col = 0;
      feed_cols(NC, 30, -1);
      chk("bp_accepted", next_col, 6);
      chk("bp_col_ready", col_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_no_pops", exp_idx, 0);
      out_ready = 1'b1;
      feed_cols(NC, 400, -1);
      wait_done(400);
      end_frame("backpressure", OC, 1'b0);

      // Kernel beats with idle cycles between them.
      run_frame(1'b1, -1);
      end_frame("kern_gaps", OC, 1'b0);

      // Watchdog: last result never arrives.
      drop_last = 1'b1;
      run_frame(1'b0, -1);
      end_frame("watchdog", OC - 1, 1'b1);
      chk("wd_delay", err_edge - last_fvo_edge, TO);
      drop_last = 1'b0;

      // start while streaming is ignored; the new frame also clears err.
      run_frame(1'b0, 5);
      end_frame("start_ignored", OC, 1'b0);

      // Reset in the middle of streaming.
      do_start();
      load_kernel(1'b0);
      next_col = 0;
      feed_cols(5, 100, -1);
      tick();
      col_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs",
          {busy, done, err, kern_ready, col_ready, out_valid, f_kernel_load, f_valid_in, f_rst},
          9'b0000_0000_1);
      repeat (3) tick();
      rst_n = 1'b1;
      col_valid = 1'b0;
      repeat (5) tick();
      chk("no_autostart", busy, 1'b0);
      run_frame(1'b0, -1);
      end_frame("after_reset", OC, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
